// File: rtl/button_conditioner_pkg.sv
// Shared types for the pushbutton conditioner: FSM state encoding and the
// debounce counter width helper.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  // Wide enough to hold 0..cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_conditioner_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable
// value loaded on reset.
module sync2 #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounces a raw pushbutton and derives level, press/release pulses, a press
// toggle and a press counter. The release pulse port is release_pulse because
// release is a SystemVerilog keyword.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       level,
  output logic       press,
  output logic       release_pulse,
  output logic       toggle,
  output logic [7:0] count
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_in;
  logic          btn_s;
  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          press_set, release_set;

  // Inverting before the synchronizer means the flops always reset to "released".
  assign btn_in = ACTIVE_LOW ? ~btn : btn;

  sync2 #(
    .RESET_VALUE(1'b0)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (btn_s)
  );

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    press_set   = 1'b0;
    release_set = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_next = DB_PRESS;
          cnt_next   = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = HELD;
          cnt_next   = '0;
          press_set  = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_next = DB_RELEASE;
          cnt_next   = '0;
        end
      end
      DB_RELEASE: begin
        if (btn_s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next  = IDLE;
          cnt_next    = '0;
          release_set = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // All outputs are registered so level and the pulses move on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      toggle        <= 1'b0;
      count         <= 8'd0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      level         <= (state_next == HELD) || (state_next == DB_RELEASE);
      press         <= press_set;
      release_pulse <= release_set;
      if (press_set) begin
        toggle <= ~toggle;
        count  <= count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized directed bench for button_conditioner (DEBOUNCE_CYCLES=4) with a
// run-length reference model; a second instance exercises ACTIVE_LOW=1.
module tb_button_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_a, btn_b;
  logic       level_a, press_a, release_a, toggle_a;
  logic       level_b, press_b, release_b, toggle_b;
  logic [7:0] count_a, count_b;

  int checks = 0;
  int passed = 0;
  int press_seen_a = 0, release_seen_a = 0;
  int press_seen_b = 0, release_seen_b = 0;

  // Reference model state, one slot per instance (0 = active-high, 1 = active-low).
  logic       m_s1[2], m_s2[2];
  int         m_run[2];
  logic       m_level[2], m_press[2], m_rel[2], m_toggle[2];
  logic [7:0] m_count[2];

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .btn(btn_a), .level(level_a), .press(press_a),
    .release_pulse(release_a), .toggle(toggle_a), .count(count_a)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .btn(btn_b), .level(level_b), .press(press_b),
    .release_pulse(release_b), .toggle(toggle_b), .count(count_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_run[i] = 0;
      m_level[i] = 1'b0; m_press[i] = 1'b0; m_rel[i] = 1'b0;
      m_toggle[i] = 1'b0; m_count[i] = 8'd0;
    end
  endtask

  // A level change needs D+1 consecutive synchronized samples that disagree with it.
  task automatic model_edge(input int i, input logic raw);
    logic seen;
    seen = m_s2[i];
    m_s2[i] = m_s1[i];
    m_s1[i] = raw;
    m_press[i] = 1'b0;
    m_rel[i] = 1'b0;
    if (seen != m_level[i]) begin
      m_run[i]++;
      if (m_run[i] == D + 1) begin
        m_run[i] = 0;
        m_level[i] = seen;
        if (seen) begin
          m_press[i] = 1'b1;
          m_toggle[i] = ~m_toggle[i];
          m_count[i] = m_count[i] + 8'd1;
        end else begin
          m_rel[i] = 1'b1;
        end
      end
    end else begin
      m_run[i] = 0;
    end
  endtask

  task automatic checkAll();
    checkOutput("level_a", level_a, m_level[0]);
    checkOutput("press_a", press_a, m_press[0]);
    checkOutput("release_a", release_a, m_rel[0]);
    checkOutput("toggle_a", toggle_a, m_toggle[0]);
    checkOutput("count_a", count_a, m_count[0]);
    checkOutput("level_b", level_b, m_level[1]);
    checkOutput("press_b", press_b, m_press[1]);
    checkOutput("release_b", release_b, m_rel[1]);
    checkOutput("toggle_b", toggle_b, m_toggle[1]);
    checkOutput("count_b", count_b, m_count[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_edge(0, btn_a);
      model_edge(1, ~btn_b);
    end
    #1;
    if (press_a) press_seen_a++;
    if (release_a) release_seen_a++;
    if (press_b) press_seen_b++;
    if (release_b) release_seen_b++;
    checkAll();
  endtask

  task automatic applyStimulus(input logic a, input logic b, input int cycles);
    btn_a = a;
    btn_b = b;
    for (int n = 0; n < cycles; n++) tick();
  endtask

  task automatic waitLevel(input int inst, input logic target, output int edges);
    edges = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (((inst == 0) ? level_a : level_b) === target) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    model_reset();
    #1;
    checkAll();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int e, p0, r0, hi;
    btn_a = 1'b0;
    btn_b = 1'b1;
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] active-low idle and press");
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("al_idle_press_pulses", press_seen_b, 0);
    btn_b = 1'b0;
    waitLevel(1, 1'b1, e);
    checkOutput("al_press_latency", e, 7);
    checkOutput("al_count", count_b, 1);
    applyStimulus(1'b0, 1'b1, 12);
    checkOutput("al_level_after_release", level_b, 0);

    $display("[TB] clean press and release");
    p0 = press_seen_a;
    btn_a = 1'b1;
    waitLevel(0, 1'b1, e);
    checkOutput("press_latency", e, 7);
    checkOutput("press_at_level_edge", press_a, 1);
    applyStimulus(1'b1, 1'b1, 13);
    checkOutput("press_pulse_count", press_seen_a - p0, 1);
    checkOutput("toggle_after_press", toggle_a, 1);
    checkOutput("count_after_press", count_a, 1);
    r0 = release_seen_a;
    btn_a = 1'b0;
    waitLevel(0, 1'b0, e);
    checkOutput("release_latency", e, 7);
    checkOutput("release_at_level_edge", release_a, 1);
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("release_pulse_count", release_seen_a - r0, 1);
    checkOutput("count_after_release", count_a, 1);

    $display("[TB] glitches");
    p0 = press_seen_a;
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 10);
    for (int g = 0; g < 8; g++) begin
      hi = $urandom_range(1, D);
      applyStimulus(1'b1, 1'b1, hi);
      applyStimulus(1'b0, 1'b1, $urandom_range(1, 6));
    end
    applyStimulus(1'b0, 1'b1, 8);
    checkOutput("glitch_no_press", press_seen_a - p0, 0);
    checkOutput("glitch_count", count_a, 1);

    $display("[TB] reset mid-debounce");
    applyStimulus(1'b1, 1'b1, 5);
    p0 = press_seen_a;
    rst = 1'b1;
    model_reset();
    #1;
    checkOutput("rst_level", level_a, 0);
    checkOutput("rst_count", count_a, 0);
    checkOutput("rst_toggle", toggle_a, 0);
    tick();
    tick();
    rst = 1'b0;
    waitLevel(0, 1'b1, e);
    checkOutput("post_reset_press_latency", e, 7);
    checkOutput("post_reset_press", press_a, 1);
    checkOutput("post_reset_count", count_a, 1);
    applyStimulus(1'b0, 1'b1, 12);

    $display("[TB] 256 bouncy press/release pairs");
    pulseReset();
    p0 = press_seen_a;
    r0 = release_seen_a;
    for (int k = 0; k < 256; k++) begin
      for (int b = 0; b < int'($urandom_range(0, 3)); b++)
        applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1);
      applyStimulus(1'b1, 1'b1, 8 + $urandom_range(0, 4));
      for (int b = 0; b < int'($urandom_range(0, 3)); b++)
        applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1);
      applyStimulus(1'b0, 1'b1, 8 + $urandom_range(0, 4));
    end
    checkOutput("wrap_count", count_a, 0);
    checkOutput("wrap_toggle", toggle_a, 0);
    checkOutput("wrap_presses", press_seen_a - p0, 256);
    checkOutput("wrap_releases", release_seen_a - r0, 256);
    checkOutput("al_untouched_presses", press_seen_b, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
